// File: rtl/fps_link_mux_if.sv
// Output stream of the link mux: one forwarded node packet per strobe.
// master drives the stream, slave consumes it.
interface fps_link_mux_if #(
  parameter int INTERLOCKS_PER_NODE = 64,
  parameter int ACQ_INDEX_WIDTH     = 6
);
  logic                           newDataStrobe;
  logic [ACQ_INDEX_WIDTH-1:0]     acqIndex;
  logic [INTERLOCKS_PER_NODE-1:0] inputState;
  logic [INTERLOCKS_PER_NODE-1:0] inputTransitions;

  modport master (output newDataStrobe, acqIndex, inputState, inputTransitions);
  modport slave  (input  newDataStrobe, acqIndex, inputState, inputTransitions);
endinterface

// File: rtl/fps_link_mux.sv
// fps_link_mux: buffers one decoded node packet per link receiver and
// round-robin forwards them onto a single interlock stream. Tracks per-node
// staleness with a shared tick prescaler and flags per-link overruns.
// Optional: define LINK_MUX_OVERRUN_COUNT_EN for saturating 16-bit per-link
// overrun counters; otherwise overrunCount reads as zero.
module fps_link_mux #(
  parameter int MAX_LINK_COUNT      = 2,
  parameter int NODES_PER_LINK      = 32,
  parameter int INTERLOCKS_PER_NODE = 64,
  parameter int ACQ_INDEX_WIDTH     = 6,
  parameter int STALE_TICK_CYCLES   = 1000,
  parameter int STALE_TICKS         = 4
) (
  input  logic                                             clk,
  input  logic                                             resetN,
  input  logic [MAX_LINK_COUNT-1:0]                        linkUp,
  input  logic [MAX_LINK_COUNT-1:0]                        linkStrobe,
  input  logic [MAX_LINK_COUNT*$clog2(NODES_PER_LINK)-1:0] linkNode,
  input  logic [MAX_LINK_COUNT*INTERLOCKS_PER_NODE-1:0]    linkState,
  input  logic [MAX_LINK_COUNT*INTERLOCKS_PER_NODE-1:0]    linkTransitions,
  input  logic                                             overrunClear,
  fps_link_mux_if.master                                   out_bus,
  output logic [NODES_PER_LINK*MAX_LINK_COUNT-1:0]         staleNodes,
  output logic [MAX_LINK_COUNT-1:0]                        overrunLinks,
  output logic [MAX_LINK_COUNT*16-1:0]                     overrunCount
);
  localparam int NODE_W     = $clog2(NODES_PER_LINK);
  localparam int PTR_W      = (MAX_LINK_COUNT > 1) ? $clog2(MAX_LINK_COUNT) : 1;
  localparam int PRESC_W    = (STALE_TICK_CYCLES > 1) ? $clog2(STALE_TICK_CYCLES) : 1;
  localparam int NODE_TOTAL = NODES_PER_LINK * MAX_LINK_COUNT;

  logic [MAX_LINK_COUNT-1:0]      hold_full;
  logic [NODE_W-1:0]              hold_node  [MAX_LINK_COUNT];
  logic [INTERLOCKS_PER_NODE-1:0] hold_state [MAX_LINK_COUNT];
  logic [INTERLOCKS_PER_NODE-1:0] hold_trans [MAX_LINK_COUNT];
  logic [MAX_LINK_COUNT-1:0]      eligible;
  logic [MAX_LINK_COUNT-1:0]      grant_oh;
  logic [MAX_LINK_COUNT-1:0]      overrun_ev;
  logic [MAX_LINK_COUNT-1:0]      overrun_q;
  logic                           grant_vld;
  logic [PTR_W-1:0]               grant_idx;
  logic [PTR_W-1:0]               ptr_q;
  logic [ACQ_INDEX_WIDTH-1:0]     grant_acq;
  logic [PRESC_W-1:0]             presc_q;
  logic                           tick;
  logic                           out_strobe_q;
  logic [ACQ_INDEX_WIDTH-1:0]     out_acq_q;
  logic [INTERLOCKS_PER_NODE-1:0] out_state_q;
  logic [INTERLOCKS_PER_NODE-1:0] out_trans_q;

  // A link that is down cannot be granted; its buffered packet is dropped.
  assign eligible = hold_full & linkUp;

  // Round-robin search: first eligible link at or after the pointer, wrapping.
  always_comb begin : arb
    int k;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = 0; i < MAX_LINK_COUNT; i++) begin
      k = int'(ptr_q) + i;
      if (k >= MAX_LINK_COUNT) k = k - MAX_LINK_COUNT;
      if (!grant_vld && eligible[k]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end

  assign grant_oh  = grant_vld ? (MAX_LINK_COUNT'(1) << grant_idx) : '0;
  assign grant_acq = ACQ_INDEX_WIDTH'(int'(grant_idx) * NODES_PER_LINK + int'(hold_node[grant_idx]));
  assign tick      = (presc_q == PRESC_W'(STALE_TICK_CYCLES - 1));

  genvar gi;
  for (gi = 0; gi < MAX_LINK_COUNT; gi++) begin : g_link
    logic                           full_q;
    logic [NODE_W-1:0]              node_q;
    logic [INTERLOCKS_PER_NODE-1:0] state_q;
    logic [INTERLOCKS_PER_NODE-1:0] trans_q;

    // Holding register: a new strobe always wins, grant empties, link-down flushes.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        full_q  <= 1'b0;
        node_q  <= '0;
        state_q <= '0;
        trans_q <= '0;
      end else if (!linkUp[gi]) begin
        full_q <= 1'b0;
      end else if (linkStrobe[gi]) begin
        full_q  <= 1'b1;
        node_q  <= linkNode[gi*NODE_W +: NODE_W];
        state_q <= linkState[gi*INTERLOCKS_PER_NODE +: INTERLOCKS_PER_NODE];
        trans_q <= linkTransitions[gi*INTERLOCKS_PER_NODE +: INTERLOCKS_PER_NODE];
      end else if (grant_oh[gi]) begin
        full_q <= 1'b0;
      end
    end

    assign hold_full[gi]  = full_q;
    assign hold_node[gi]  = node_q;
    assign hold_state[gi] = state_q;
    assign hold_trans[gi] = trans_q;
    // A packet is lost only when the buffered one is not leaving this cycle.
    assign overrun_ev[gi] = linkUp[gi] & linkStrobe[gi] & full_q & ~grant_oh[gi];

`ifdef LINK_MUX_OVERRUN_COUNT_EN
    logic [15:0] cnt_q;
    // Saturating overrun counter; an event in the clear cycle counts as 1.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) cnt_q <= '0;
      else if (overrunClear) cnt_q <= {15'd0, overrun_ev[gi]};
      else if (overrun_ev[gi] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign overrunCount[gi*16 +: 16] = cnt_q;
`else
    assign overrunCount[gi*16 +: 16] = 16'd0;
`endif
  end

  // Sticky overrun flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) overrun_q <= '0;
    else overrun_q <= (overrunClear ? '0 : overrun_q) | overrun_ev;
  end

  // Arbiter pointer advances past the granted link.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ptr_q <= '0;
    else if (grant_vld) ptr_q <= (int'(grant_idx) == MAX_LINK_COUNT - 1) ? '0 : grant_idx + 1'b1;
  end

  // Forwarded packet register; bus holds its last value when idle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_strobe_q <= 1'b0;
      out_acq_q    <= '0;
      out_state_q  <= '0;
      out_trans_q  <= '0;
    end else begin
      out_strobe_q <= grant_vld;
      if (grant_vld) begin
        out_acq_q   <= grant_acq;
        out_state_q <= hold_state[grant_idx];
        out_trans_q <= hold_trans[grant_idx];
      end
    end
  end

  // Free-running prescaler producing the staleness tick.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) presc_q <= '0;
    else presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  for (gi = 0; gi < NODE_TOTAL; gi++) begin : g_node
    logic [3:0] timer_q;
    logic [3:0] timer_d;
    logic       stale_q;
    logic       reload;

    assign reload = grant_vld && (grant_acq == ACQ_INDEX_WIDTH'(gi));

    // Timer next state: link-down clears, reload beats tick, tick counts down to 0.
    always_comb begin
      timer_d = timer_q;
      if (!linkUp[gi / NODES_PER_LINK]) timer_d = 4'd0;
      else if (reload) timer_d = 4'(STALE_TICKS);
      else if (tick && timer_q != 4'd0) timer_d = timer_q - 4'd1;
    end

    // Stale flag registered alongside the timer so it clears with the strobe.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        timer_q <= 4'd0;
        stale_q <= 1'b1;
      end else begin
        timer_q <= timer_d;
        stale_q <= (timer_d == 4'd0);
      end
    end

    assign staleNodes[gi] = stale_q;
  end

  assign overrunLinks             = overrun_q;
  assign out_bus.newDataStrobe    = out_strobe_q;
  assign out_bus.acqIndex         = out_acq_q;
  assign out_bus.inputState       = out_state_q;
  assign out_bus.inputTransitions = out_trans_q;
endmodule

// File: tb/tb_fps_link_mux.sv
// Self-checking bench for fps_link_mux: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_fps_link_mux;
  localparam int L  = 2;
  localparam int N  = 32;
  localparam int I  = 64;
  localparam int A  = 6;
  localparam int C  = 10;
  localparam int T  = 2;
  localparam int NW = 5;

  logic           clk = 1'b0;
  logic           resetN;
  logic [L-1:0]   linkUp;
  logic [L-1:0]   linkStrobe;
  logic [L*NW-1:0] linkNode;
  logic [L*I-1:0] linkState;
  logic [L*I-1:0] linkTransitions;
  logic           overrunClear;
  logic [N*L-1:0] staleNodes;
  logic [L-1:0]   overrunLinks;
  logic [L*16-1:0] overrunCount;

  fps_link_mux_if #(.INTERLOCKS_PER_NODE(I), .ACQ_INDEX_WIDTH(A)) bus ();

  fps_link_mux #(
    .MAX_LINK_COUNT(L), .NODES_PER_LINK(N), .INTERLOCKS_PER_NODE(I),
    .ACQ_INDEX_WIDTH(A), .STALE_TICK_CYCLES(C), .STALE_TICKS(T)
  ) dut (
    .clk(clk), .resetN(resetN), .linkUp(linkUp), .linkStrobe(linkStrobe),
    .linkNode(linkNode), .linkState(linkState), .linkTransitions(linkTransitions),
    .overrunClear(overrunClear), .out_bus(bus), .staleNodes(staleNodes),
    .overrunLinks(overrunLinks), .overrunCount(overrunCount)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  bit          m_pend   [L];
  int          m_pnode  [L];
  logic [63:0] m_pst    [L];
  logic [63:0] m_ptr_t  [L];
  int          m_rr;
  bit          m_ds;
  int          m_acq;
  logic [63:0] m_st, m_tr;
  int          cyc_mod;
  int          tick_count;
  bit          alive    [N*L];
  int          reload_at[N*L];
  logic [L-1:0] m_ovr;
  logic [15:0] m_cnt    [L];

  task automatic model_reset();
    for (int k = 0; k < L; k++) begin
      m_pend[k] = 0; m_pnode[k] = 0; m_pst[k] = '0; m_ptr_t[k] = '0; m_cnt[k] = '0;
    end
    for (int i = 0; i < N*L; i++) begin alive[i] = 0; reload_at[i] = 0; end
    m_rr = 0; m_ds = 0; m_acq = 0; m_st = '0; m_tr = '0;
    cyc_mod = 0; tick_count = 0; m_ovr = '0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    int g;
    bit tk;
    g = -1;
    for (int i = 0; i < L; i++) begin
      int k;
      k = (m_rr + i) % L;
      if (g < 0 && m_pend[k] && linkUp[k]) g = k;
    end
    tk = (cyc_mod == C - 1);
    cyc_mod = (cyc_mod + 1) % C;
    if (tk) tick_count++;
    if (g >= 0) begin
      m_ds = 1; m_acq = g * N + m_pnode[g]; m_st = m_pst[g]; m_tr = m_ptr_t[g];
      alive[m_acq] = 1; reload_at[m_acq] = tick_count;
      m_rr = (g + 1) % L;
    end else begin
      m_ds = 0;
    end
    if (overrunClear) begin
      m_ovr = '0;
      for (int k = 0; k < L; k++) m_cnt[k] = '0;
    end
    for (int k = 0; k < L; k++) begin
      if (!linkUp[k]) begin
        m_pend[k] = 0;
        for (int n = 0; n < N; n++) alive[k*N + n] = 0;
      end else if (linkStrobe[k]) begin
        if (m_pend[k] && g != k) begin
          m_ovr[k] = 1'b1;
`ifdef LINK_MUX_OVERRUN_COUNT_EN
          if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
`endif
        end
        m_pend[k] = 1; m_pnode[k] = int'(linkNode[k*NW +: NW]);
        m_pst[k] = linkState[k*I +: I]; m_ptr_t[k] = linkTransitions[k*I +: I];
      end else if (g == k) begin
        m_pend[k] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [63:0] es;
    for (int i = 0; i < N*L; i++) es[i] = !alive[i] || ((tick_count - reload_at[i]) >= T);
    check("strobe", 64'(bus.newDataStrobe), 64'(m_ds));
    check("acqIndex", 64'(bus.acqIndex), 64'(m_acq));
    check("inputState", bus.inputState, m_st);
    check("inputTransitions", bus.inputTransitions, m_tr);
    check("staleNodes", staleNodes, es);
    check("overrunLinks", 64'(overrunLinks), 64'(m_ovr));
    check("overrunCount", 64'(overrunCount), 64'({m_cnt[1], m_cnt[0]}));
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_link(input int k, input int node, input logic [63:0] st, input logic [63:0] tr);
    linkStrobe[k] = 1'b1;
    linkNode[k*NW +: NW] = NW'(node);
    linkState[k*I +: I] = st;
    linkTransitions[k*I +: I] = tr;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  strobe;
    logic [4:0]  node0, node1;
    logic [63:0] st0, tr0, st1, tr1;
    logic        e_ds;
    logic [5:0]  e_acq;
    logic [63:0] e_st, e_tr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int d;
    int ds_cnt;
    vecs[0] = '{2'b10, 5'd0, 5'd5, 64'h0,  64'h0,  64'hA5, 64'h01, 1'b0, 6'd0,  64'h0,  64'h0};
    vecs[1] = '{2'b00, 5'd0, 5'd0, 64'h0,  64'h0,  64'h0,  64'h0,  1'b1, 6'd37, 64'hA5, 64'h01};
    vecs[2] = '{2'b11, 5'd7, 5'd9, 64'h11, 64'h22, 64'h33, 64'h44, 1'b0, 6'd37, 64'hA5, 64'h01};
    vecs[3] = '{2'b00, 5'd0, 5'd0, 64'h0,  64'h0,  64'h0,  64'h0,  1'b1, 6'd7,  64'h11, 64'h22};
    vecs[4] = '{2'b00, 5'd0, 5'd0, 64'h0,  64'h0,  64'h0,  64'h0,  1'b1, 6'd41, 64'h33, 64'h44};
    vecs[5] = '{2'b00, 5'd0, 5'd0, 64'h0,  64'h0,  64'h0,  64'h0,  1'b0, 6'd41, 64'h33, 64'h44};

    resetN = 1'b0; linkUp = 2'b11; linkStrobe = '0; linkNode = '0;
    linkState = '0; linkTransitions = '0; overrunClear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", 64'(bus.newDataStrobe), 64'd0);
    check("rst_stale", staleNodes, {64{1'b1}});
    check("rst_overrun", 64'(overrunLinks), 64'd0);
    check("rst_count", 64'(overrunCount), 64'd0);
    check("rst_acq", 64'(bus.acqIndex), 64'd0);
    resetN = 1'b1;

    // Idle with all links up: nothing forwarded, everything stale.
    repeat (20) tick_cycle();
    check("idle_stale", staleNodes, {64{1'b1}});
    $display("idle: 20 cycles, strobe=%0b overrun=%b", bus.newDataStrobe, overrunLinks);

    // Table-driven vectors.
    for (int v = 0; v < 6; v++) begin
      linkStrobe = '0;
      if (vecs[v].strobe[0]) set_link(0, int'(vecs[v].node0), vecs[v].st0, vecs[v].tr0);
      if (vecs[v].strobe[1]) set_link(1, int'(vecs[v].node1), vecs[v].st1, vecs[v].tr1);
      tick_cycle();
      check("vec_strobe", 64'(bus.newDataStrobe), 64'(vecs[v].e_ds));
      check("vec_acq", 64'(bus.acqIndex), 64'(vecs[v].e_acq));
      check("vec_state", bus.inputState, vecs[v].e_st);
      check("vec_trans", bus.inputTransitions, vecs[v].e_tr);
      check("vec_overrun", 64'(overrunLinks), 64'd0);
      if (v == 1) check("vec_stale37", 64'(staleNodes[37]), 64'd0);
      $display("vec %0d: strobe=%0b acq=%0d state=%h trans=%h", v, bus.newDataStrobe,
               bus.acqIndex, bus.inputState, bus.inputTransitions);
    end
    linkStrobe = '0;

    // Staleness delay of node 3 after a single packet.
    set_link(0, 3, 64'h3, 64'h0);
    tick_cycle();
    linkStrobe = '0;
    tick_cycle();
    check("stale_fwd_acq", 64'(bus.acqIndex), 64'd3);
    d = 0;
    while (d < 40 && !(staleNodes[3] === 1'b1)) begin tick_cycle(); d++; end
    n_cmp++;
    if (!(staleNodes[3] === 1'b1 && d >= 11 && d <= 20)) begin
      n_fail++;
      $display("FAIL stale_delay: got %0d cycles (stale=%b) expected 11..20", d, staleNodes[3]);
    end
    $display("stale: node 3 stale %0d cycles after forwarding", d);

    // Reload colliding with a tick keeps node 3 fresh for a full period.
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < C && cyc_mod != C - 2; w++) tick_cycle();
      set_link(0, 3, 64'(r), 64'h0);
      tick_cycle();
      linkStrobe = '0;
      tick_cycle();
    end
    repeat (15) tick_cycle();
    check("collision_fresh", 64'(staleNodes[3]), 64'd0);
    repeat (10) tick_cycle();
    check("collision_stale", 64'(staleNodes[3]), 64'd1);
    $display("collision: node 3 stale=%0b 25 cycles after tick-aligned reload", staleNodes[3]);

    // Link 1 drop with a packet pending.
    for (int n = 0; n < 9; n++) begin
      linkStrobe = '0;
      set_link(1, n, rnd64(), rnd64());
      tick_cycle();
    end
    linkStrobe = '0;
    set_link(1, 10, 64'hDEAD, 64'hBEEF);
    tick_cycle();
    check("linkdown_fresh", 64'(staleNodes[40:32]), 64'd0);
    linkStrobe = '0;
    linkUp[1] = 1'b0;
    tick_cycle();
    check("linkdown_stale", 64'(staleNodes[63:32]), 64'hFFFF_FFFF);
    ds_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.newDataStrobe === 1'b1) ds_cnt++;
      tick_cycle();
    end
    check("linkdown_no_fwd", 64'(ds_cnt), 64'd0);
    $display("linkdown: link 1 stale=%h forwarded=%0d", staleNodes[63:32], ds_cnt);
    linkUp = 2'b11;

    // Overruns on both links.
    overrunClear = 1'b1;
    tick_cycle();
    overrunClear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      set_link(0, c, rnd64(), rnd64());
      set_link(1, c + 8, rnd64(), rnd64());
      tick_cycle();
    end
    linkStrobe = '0;
    repeat (3) tick_cycle();
    check("overrun_flags", 64'(overrunLinks), 64'h3);
`ifdef LINK_MUX_OVERRUN_COUNT_EN
    check("overrun_counts", 64'(overrunCount), 64'h0003_0002);
`else
    check("overrun_count_tied", 64'(overrunCount), 64'd0);
`endif
    $display("overrun: flags=%b count=%h", overrunLinks, overrunCount);
    overrunClear = 1'b1;
    tick_cycle();
    overrunClear = 1'b0;
    check("clear_flags", 64'(overrunLinks), 64'd0);
    check("clear_counts", 64'(overrunCount), 64'd0);

    // Overrun coinciding with clear: link 1 granted, link 0 loses a packet.
    set_link(0, 1, rnd64(), rnd64());
    set_link(1, 1, rnd64(), rnd64());
    tick_cycle();
    set_link(0, 2, rnd64(), rnd64());
    set_link(1, 2, rnd64(), rnd64());
    overrunClear = 1'b1;
    tick_cycle();
    overrunClear = 1'b0;
    linkStrobe = '0;
    check("clear_vs_event_flags", 64'(overrunLinks), 64'h1);
`ifdef LINK_MUX_OVERRUN_COUNT_EN
    check("clear_vs_event_count", 64'(overrunCount), 64'h0000_0001);
`endif
    $display("clear+event: flags=%b count=%h", overrunLinks, overrunCount);
    repeat (3) tick_cycle();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      linkStrobe = '0;
      overrunClear = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 63) == 0) linkUp[k] = ~linkUp[k];
        if ($urandom_range(0, 9) < 4) set_link(k, int'($urandom_range(0, N - 1)), rnd64(), rnd64());
      end
      tick_cycle();
    end
    $display("random: 1500 cycles, flags=%b count=%h", overrunLinks, overrunCount);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
